// File: rtl/rgb_palette_encoder.sv
`default_nettype none
// ============================================================================
// rgb_palette_encoder - 12-bit RGB to 3-bit sprite palette index, BRAM writer
// Rev 1.0
// ============================================================================
module rgb_palette_encoder #(
  parameter int          DEPTH           = 4096,
  parameter int          ADDR_W          = 12,
  parameter logic [11:0] TRANSPARENT_KEY = 12'h0F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [11:0]       in_rgb,
  output logic              in_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [2:0]        bram_din,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic              in_ready_q;
  logic              done_q;
  logic [ADDR_W-1:0] cnt_q;

  logic              s1_valid_q;
  logic [11:0]       s1_rgb_q;
  logic [ADDR_W-1:0] s1_seq_q;

  logic              s2_valid_q;
  logic              s2_key_q;
  logic [4:0][5:0]   s2_dist_q;
  logic [ADDR_W-1:0] s2_seq_q;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        din_q;

  logic              accept;
  logic [4:0][5:0]   dist_d;
  logic [2:0]        idx_d;
  logic [5:0]        best_dist;

  // Palette entries 1..5 live at positions 0..4.
  function automatic logic [11:0] centroid(input int i);
    case (i)
      0:       return 12'hD42;
      1:       return 12'h921;
      2:       return 12'hFF9;
      3:       return 12'h210;
      4:       return 12'h778;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [5:0] absdiff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? {2'b00, a - b} : {2'b00, b - a};
  endfunction

  function automatic logic [5:0] dist_fn(input logic [11:0] p, input logic [11:0] q);
    return absdiff(p[11:8], q[11:8]) + absdiff(p[7:4], q[7:4]) + absdiff(p[3:0], q[3:0]);
  endfunction

  assign accept = in_valid & in_ready_q;

  always_comb begin
    dist_d = '0;
    for (int i = 0; i < 5; i++) begin
      dist_d[i] = dist_fn(s1_rgb_q, centroid(i));
    end
  end

  // Strict less-than keeps the lowest index on a tie.
  always_comb begin
    best_dist = s2_dist_q[0];
    idx_d     = 3'd1;
    for (int i = 1; i < 5; i++) begin
      if (s2_dist_q[i] < best_dist) begin
        best_dist = s2_dist_q[i];
        idx_d     = 3'(i + 1);
      end
    end
    if (s2_key_q) begin
      idx_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q == C_LAST) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_q && !s2_valid_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
      s1_seq_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_key_q   <= 1'b0;
      s2_dist_q  <= '0;
      s2_seq_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_rgb_q <= in_rgb;
        s1_seq_q <= cnt_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_key_q   <= (s1_rgb_q == TRANSPARENT_KEY);
      s2_dist_q  <= dist_d;
      s2_seq_q   <= s1_seq_q;
      we_q       <= s2_valid_q;
      if (s2_valid_q) begin
        addr_q <= s2_seq_q;
        din_q  <= idx_d;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_palette_encoder.sv
`default_nettype none
// ============================================================================
// tb_rgb_palette_encoder - randomized bench with a behavioural palette model
// Rev 1.0
// ============================================================================
module tb_rgb_palette_encoder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame_start;
  logic              in_valid;
  logic [11:0]       in_rgb;
  logic              in_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [2:0]        bram_din;
  logic              busy;
  logic              frame_done;

  rgb_palette_encoder #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .TRANSPARENT_KEY(12'h0F0)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .in_rgb     (in_rgb),
    .in_ready   (in_ready),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference palette mapping from the colour-distance rule.
  int pal [0:4] = '{'hD42, 'h921, 'hFF9, 'h210, 'h778};

  function automatic int ref_index(input logic [11:0] rgb);
    int best, idx, d, a, b;
    if (rgb == 12'h0F0) return 0;
    best = 1000;
    idx  = 0;
    for (int i = 0; i < 5; i++) begin
      d = 0;
      for (int ch = 0; ch < 3; ch++) begin
        a = (int'(rgb) >> (4 * ch)) & 15;
        b = (pal[i] >> (4 * ch)) & 15;
        d += (a > b) ? a - b : b - a;
      end
      if (d < best) begin
        best = d;
        idx  = i + 1;
      end
    end
    return idx;
  endfunction

  // Model: frame phase (0 idle, 1 loading, 2 draining) and expected writes keyed by edge number.
  int cyc       = 0;
  int m_phase   = 0;
  int m_cnt     = 0;
  int done_edge = -1;
  int exp_addr [int];
  int exp_din  [int];
  int exp_done [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      exp_addr.delete();
      exp_din.delete();
      exp_done.delete();
    end else begin
      cyc++;
      case (m_phase)
        0: if (frame_start) begin
             m_phase = 1;
             m_cnt   = 0;
           end
        1: if (in_valid) begin
             exp_addr[cyc + 2] = m_cnt;
             exp_din[cyc + 2]  = ref_index(in_rgb);
             m_cnt++;
             if (m_cnt == DEPTH) begin
               m_phase   = 2;
               done_edge = cyc + 3;
             end
           end
        default: if (cyc == done_edge) begin
             m_phase        = 0;
             exp_done[cyc]  = 1;
           end
      endcase
    end
  end

  int log_addr[$];
  int log_din[$];
  int log_cyc[$];
  int n_done   = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    bit ew;
    ew = exp_addr.exists(cyc) != 0;
    check("bram_we", bram_we, ew);
    if (ew && bram_we) begin
      check("bram_addr", bram_addr, exp_addr[cyc]);
      check("bram_din", bram_din, exp_din[cyc]);
    end
    check("frame_done", frame_done, exp_done.exists(cyc) != 0);
    check("busy", busy, m_phase != 0);
    check("in_ready", in_ready, m_phase == 1);
    if (bram_we === 1'b1) begin
      log_addr.push_back(int'(bram_addr));
      log_din.push_back(int'(bram_din));
      log_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
    log_cyc.delete();
    n_done = 0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [11:0] rgb);
    in_valid = 1'b1;
    in_rgb   = rgb;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 200 && m_phase != 0; i++) begin
      in_valid = ($urandom % 2) != 0;
      in_rgb   = 12'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("frame_completes", busy, 1'b0);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_rgb      = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_we", bram_we, 1'b0);
    check("rst_addr", bram_addr, 0);
    check("rst_din", bram_din, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_done", frame_done, 1'b0);
    repeat (3) tick();
    rst = 1'b0;

    // Idle: valid pixels without frame_start are ignored.
    clear_log();
    in_valid = 1'b1;
    in_rgb   = 12'hD42;
    repeat (6) tick();
    in_valid = 1'b0;
    check("idle_no_writes", log_addr.size(), 0);

    // Exact centroids plus the transparent key.
    clear_log();
    pulse_start();
    send(12'hD42); send(12'h921); send(12'hFF9);
    send(12'h210); send(12'h778); send(12'h0F0);
    finish_frame();
    check("cent_count", log_din.size(), DEPTH);
    if (log_din.size() >= 6) begin
      check("cent_d0", log_din[0], 1); check("cent_d1", log_din[1], 2);
      check("cent_d2", log_din[2], 3); check("cent_d3", log_din[3], 4);
      check("cent_d4", log_din[4], 5); check("cent_d5", log_din[5], 0);
      check("cent_a5", log_addr[5], 5);
      check("cent_consecutive", log_cyc[5] - log_cyc[0], 5);
    end

    // Nearest match and tie-break.
    clear_log();
    pulse_start();
    send(12'h000); send(12'hFFF); send(12'h845);
    finish_frame();
    if (log_din.size() >= 3) begin
      check("near_000", log_din[0], 4);
      check("near_FFF", log_din[1], 3);
      check("tie_845", log_din[2], 2);
    end else begin
      check("near_count", log_din.size(), 3);
    end

    // Full frame with 1,0,1,1,0 valid gaps.
    clear_log();
    pulse_start();
    for (int i = 0; i < 60 && m_phase == 1; i++) begin
      in_valid = (i % 5 == 0) || (i % 5 == 2) || (i % 5 == 3);
      in_rgb   = 12'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("gap_count", log_addr.size(), DEPTH);
    for (int i = 0; i < log_addr.size() && i < DEPTH; i++) check("gap_order", log_addr[i], i);
    check("gap_done_once", n_done, 1);
    if (log_cyc.size() > 0) check("gap_done_timing", done_cyc, log_cyc[log_cyc.size() - 1] + 1);
    check("gap_idle", busy, 1'b0);

    // frame_start during LOAD is ignored.
    clear_log();
    pulse_start();
    send(12'($urandom)); send(12'($urandom)); send(12'($urandom));
    frame_start = 1'b1;
    send(12'($urandom));
    frame_start = 1'b0;
    finish_frame();
    check("restart_count", log_addr.size(), DEPTH);
    for (int i = 0; i < log_addr.size() && i < DEPTH; i++) check("restart_order", log_addr[i], i);

    // Asynchronous reset mid-frame.
    pulse_start();
    send(12'hD42); send(12'h921); send(12'hFF9);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_we", bram_we, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", in_ready, 1'b0);
    clear_log();
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    in_valid = 1'b0;
    check("arst_no_writes", log_addr.size(), 0);
    pulse_start();
    send(12'h778);
    finish_frame();
    if (log_addr.size() > 0) begin
      check("arst_restart_addr", log_addr[0], 0);
      check("arst_restart_din", log_din[0], 5);
    end else begin
      check("arst_restart_count", log_addr.size(), DEPTH);
    end

    // Randomized frames with stray frame_start pulses and key pixels.
    for (int f = 0; f < 8; f++) begin
      pulse_start();
      for (int i = 0; i < 300 && m_phase != 0; i++) begin
        in_valid    = $urandom_range(0, 3) != 0;
        frame_start = ($urandom % 16) == 0;
        in_rgb      = (($urandom % 8) == 0) ? 12'h0F0 : 12'($urandom);
        tick();
      end
      in_valid    = 1'b0;
      frame_start = 1'b0;
      check("rand_frame_completes", busy, 1'b0);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
